multicycle_ctrl: RTL and testbench

- Main control FSM of the multi-clock MIPS datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives all datapath enables and muxes, and produces the 2-bit ALUop that the ALU control decoder combines with the funct field to select ALU operations.
- Stalls on a single-signal memory ready handshake.

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-clock MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// drives every datapath enable and mux select, and emits the 2-bit ALUop
// consumed by the ALU control decoder.
//
// Optional feature: define MULTICYCLE_CTRL_ADDI_EN to build the addi path
// (I_EXEC, I_WB). Without it, opcode 001000 is reported as illegal.
//
// Memory handshake: mem_ready is a single-cycle completion flag. It is
// only looked at in FETCH, MEM_READ and MEM_WRITE; in those states the
// request is held steady until a cycle with mem_ready=1, which completes
// the access and advances the FSM. It is ignored everywhere else.
module multicycle_ctrl #(
    parameter int unsigned RESET_IDLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUop,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    // Last idle count value before leaving IDLE; IDLE lasts RESET_IDLE_CYCLES cycles.
    localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] idle_cnt_q;
    logic [3:0] idle_cnt_d;

    assign state = state_q;

    // State register and post-reset idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Next-state logic and state-decoded controls (PCWrite/IRWrite in FETCH follow mem_ready).
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = '0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUop       = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (idle_cnt_q == IDLE_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_I_EXEC;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            // Unused codes recover to FETCH with every control held low.
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Expected per-cycle behaviour is built as
// a list of steps per instruction class, with random memory wait states.
module tb_multicycle_ctrl;

    localparam int IDLE_N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ALUop, PCSource;
    logic [3:0] state;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic ill;
    } exp_t;

    typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_J, C_ADDI, C_ILL} cls_t;

    logic [20:0] exp_q[$];
    logic        mr_q[$];
    logic [5:0]  op_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_IDLE_CYCLES(IDLE_N)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .PCSource(PCSource), .illegal(illegal), .state(state)
    );

    function automatic logic [20:0] actual();
        return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, illegal};
    endfunction

    // ---------------- reference model ----------------
    function automatic cls_t classify(input logic [5:0] op);
        case (op)
            6'b000000: return C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
`ifdef MULTICYCLE_CTRL_ADDI_EN
            6'b001000: return C_ADDI;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    task automatic push(input exp_t e, input logic mr, input logic [5:0] op);
        exp_q.push_back(e);
        mr_q.push_back(mr);
        op_q.push_back(op);
    endtask

    // One instruction: fw FETCH wait cycles, mw memory wait cycles.
    task automatic model_instr(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        cls_t c;
        c = classify(op);
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.st = 4'd1; e.mrd = 1'b1; e.asb = 2'b01;
            if (i == fw) begin e.pcw = 1'b1; e.irw = 1'b1; end
            push(e, (i == fw), 6'($urandom));
        end
        e = '0; e.st = 4'd2; e.asb = 2'b11; e.ill = (c == C_ILL);
        push(e, 1'($urandom), op);
        case (c)
            C_LW, C_SW: begin
                e = '0; e.st = 4'd3; e.asa = 1'b1; e.asb = 2'b10;
                push(e, 1'($urandom), op);
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.iord = 1'b1;
                    if (c == C_LW) begin e.st = 4'd4; e.mrd = 1'b1; end
                    else begin e.st = 4'd6; e.mwr = 1'b1; end
                    push(e, (i == mw), op);
                end
                if (c == C_LW) begin
                    e = '0; e.st = 4'd5; e.rw = 1'b1; e.m2r = 1'b1;
                    push(e, 1'($urandom), op);
                end
            end
            C_R: begin
                e = '0; e.st = 4'd7; e.asa = 1'b1; e.aop = 2'b10;
                push(e, 1'($urandom), op);
                e = '0; e.st = 4'd8; e.rw = 1'b1; e.rdst = 1'b1;
                push(e, 1'($urandom), op);
            end
            C_BEQ: begin
                e = '0; e.st = 4'd9; e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01;
                push(e, 1'($urandom), op);
            end
            C_J: begin
                e = '0; e.st = 4'd10; e.pcw = 1'b1; e.pcs = 2'b10;
                push(e, 1'($urandom), op);
            end
            C_ADDI: begin
                e = '0; e.st = 4'd11; e.asa = 1'b1; e.asb = 2'b10;
                push(e, 1'($urandom), op);
                e = '0; e.st = 4'd12; e.rw = 1'b1;
                push(e, 1'($urandom), op);
            end
            default: ;
        endcase
    endtask

    // ---------------- driver / scoreboard ----------------
    // Plays the queued steps (stop_after=0: all) and checks each cycle.
    task automatic run_model(input string name, input int stop_after);
        int n;
        exp_t e;
        logic [20:0] a;
        n = exp_q.size();
        if (stop_after > 0 && stop_after < n) n = stop_after;
        for (int i = 0; i < n; i++) begin
            opcode = op_q[i];
            mem_ready = mr_q[i];
            #1;
            e = exp_q[i];
            a = actual();
            checks++;
            if (a !== e)
                $display("FAIL %s step %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                         name, i, a[20:17], a[16:0], e.st, e[16:0]);
            else passed++;
            @(negedge clk);
        end
        if (stop_after == 0) begin
            #1;
            checks++;
            if (state !== 4'd1)
                $display("FAIL %s_return_fetch: got state=%0d, expected 1", name, state);
            else passed++;
        end
        exp_q.delete();
        mr_q.delete();
        op_q.delete();
    endtask

    task automatic release_and_idle(input string name);
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < IDLE_N; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (actual() !== 21'd0)
                $display("FAIL %s_idle cycle %0d: got %h, expected 0", name, i, actual());
            else passed++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd1)
            $display("FAIL %s_idle_exit: got state=%0d, expected 1", name, state);
        else passed++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        opcode = 6'($urandom);
        mem_ready = 1'b1;
        #12;
        checks++;
        if (actual() !== 21'd0)
            $display("FAIL reset_outputs: got %h, expected 0", actual());
        else passed++;
        release_and_idle("reset");
    endtask

    task automatic test_lw_wait();
        model_instr(6'b100011, 2, 3);
        run_model("lw_wait", 0);
    endtask

    task automatic test_rtype();
        model_instr(6'b000000, 0, 0);
        run_model("rtype", 0);
    endtask

    task automatic test_branch_jump();
        model_instr(6'b000100, 0, 0);
        run_model("beq", 0);
        model_instr(6'b000010, 1, 0);
        run_model("jump", 0);
        model_instr(6'b101011, 0, 2);
        run_model("sw_wait", 0);
    endtask

    task automatic test_illegal();
        model_instr(6'b111111, 0, 0);
        run_model("illegal", 0);
    endtask

    task automatic test_addi();
        model_instr(6'b001000, 0, 0);
        run_model("addi", 0);
    endtask

    // Cycle count FETCH..FETCH with mem_ready tied high.
    task automatic test_latency();
        logic [5:0] ops [7];
        int lat [7];
        int cyc;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
`ifdef MULTICYCLE_CTRL_ADDI_EN
        lat = '{4, 5, 4, 3, 3, 4, 2};
`else
        lat = '{4, 5, 4, 3, 3, 2, 2};
`endif
        for (int k = 0; k < 7; k++) begin
            opcode = ops[k];
            mem_ready = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (state != 4'd1 && cyc < 20);
            checks++;
            if (cyc != lat[k])
                $display("FAIL latency op=%b: got %0d cycles, expected %0d", ops[k], cyc, lat[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pool [7];
        logic [5:0] op;
        pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
        for (int k = 0; k < 30; k++) begin
            op = pool[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            model_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_model("back_to_back", 0);
    endtask

    task automatic test_reset_mid();
        model_instr(6'b100011, 0, 6);
        run_model("mid_pre", 5);
        opcode = 6'b100011;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== 4'd4 || MemRead !== 1'b1)
            $display("FAIL mid_in_mem_read: got state=%0d MemRead=%b, expected 4/1", state, MemRead);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (actual() !== 21'd0)
            $display("FAIL mid_reset_outputs: got %h, expected 0", actual());
        else passed++;
        release_and_idle("mid_reset");
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_rtype();
        test_branch_jump();
        test_illegal();
        test_addi();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
